// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with input synchroniser, false-start
// rejection, run-time parity selection, framing/parity/overrun reporting and a
// one-entry valid/ready holding register on the output.
// Optional build macro: UART_RX_MAJORITY_EN -- every bit decision becomes the
// 2-of-3 majority of the last three rx_s values ending at the sample point.
module uart_rx_ext #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 521,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 rx_i,
    input  logic [1:0]           parity_mode_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0]   BIT_ONE   = BCW'(1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]   shift_r;
    logic [1:0]             par_mode;
    logic                   par_flag;
    logic                   frame_flag;
    logic                   stop_idx;
    logic                   samp;
    logic                   sample_pt;

    // 2-of-3 vote used when majority sampling is built in
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity check: mode[1] selects odd parity (expected bit is inverted XOR)
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic [1:0]           mode,
                                        input logic                 bit_in);
        return bit_in != ((^d) ^ mode[1]);
    endfunction

    // Two-flop synchroniser, idles high so reset looks like an idle line
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two previous rx_s values; together with the current rx_s they form the
    // three-sample window ending at the sample point
    logic [1:0] hist;

    // Shift rx_s history every cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign samp = maj3(hist[1], hist[0], rx_s);
`else
    assign samp = rx_s;
`endif

    assign sample_pt = (cnt == CNT_LAST);
    assign busy_o    = (state != IDLE);

    // Receive FSM plus holding register and error flags
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_r      <= '0;
            par_mode     <= 2'b00;
            par_flag     <= 1'b0;
            frame_flag   <= 1'b0;
            stop_idx     <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        cnt        <= '0;
                        par_mode   <= parity_mode_i;
                        par_flag   <= 1'b0;
                        frame_flag <= 1'b0;
                        bit_cnt    <= '0;
                        stop_idx   <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= samp ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        cnt     <= '0;
                        shift_r <= {samp, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= (par_mode == 2'b01 || par_mode == 2'b10) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (sample_pt) begin
                        cnt      <= '0;
                        par_flag <= parity_bad(shift_r, par_mode, samp);
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_pt) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            // Accept into the holding register if it is empty or
                            // being drained this very cycle, otherwise drop
                            if (!valid_o || ready_i) begin
                                data_o       <= shift_r;
                                parity_err_o <= par_flag;
                                frame_err_o  <= frame_flag | ~samp;
                                valid_o      <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                            state <= samp ? IDLE : WAIT_HIGH;
                        end else begin
                            stop_idx   <= 1'b1;
                            frame_flag <= frame_flag | ~samp;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext at 16 clocks per bit, 8 data bits, 1 stop bit.
module tb_uart_rx_ext;

    localparam int CPB = 16;

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       rx_i = 1'b1;
    logic [1:0] parity_mode_i = 2'b00;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    typedef struct {
        bit         is_ovr;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    uart_rx_ext #(
        .DATA_BITS   (8),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1),
        .CNT_W       (10)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .rx_i         (rx_i),
        .parity_mode_i(parity_mode_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_word(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.is_ovr = 1'b0;
        e.d      = d;
        e.pe     = pe;
        e.fe     = fe;
        exp_q.push_back(e);
    endtask

    task automatic push_ovr();
        exp_t e;
        e.is_ovr = 1'b1;
        e.d      = '0;
        e.pe     = 1'b0;
        e.fe     = 1'b0;
        exp_q.push_back(e);
    endtask

    // Drives one frame; optional ready pulse exactly at the final stop-sample
    // edge, optional one-cycle line inversion, optional mid-frame mode change.
    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic sbit, input bit rdy_pulse, input int glitch_t,
                              input bit chg_mode, input logic [1:0] new_mode);
        logic [11:0] bits;
        int          nb;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (has_par) begin
            bits[9]  = pbit;
            bits[10] = sbit;
            nb       = 11;
        end else begin
            bits[9] = sbit;
            nb      = 10;
        end
        for (int t = 0; t < CPB * nb; t++) begin
            rx_i = bits[t / CPB] ^ (t == glitch_t);
            if (rdy_pulse) ready_i = (t == CPB * nb - 5);
            if (chg_mode && t == 20) parity_mode_i = new_mode;
            tick();
        end
    endtask

    // Monitor: a word event is valid_o high after an empty or drained cycle
    initial begin
        logic pv;
        logic pa;
        exp_t e;
        pv = 1'b0;
        pa = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                pv = 1'b0;
                pa = 1'b0;
            end else begin
                if (valid_o && (!pv || pa)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got data %0h, no word expected", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check1("word_not_overrun", 32'(e.is_ovr), 32'd0);
                        check1("data", 32'(data_o), 32'(e.d));
                        check1("parity_err", 32'(parity_err_o), 32'(e.pe));
                        check1("frame_err", 32'(frame_err_o), 32'(e.fe));
                    end
                end
                if (overrun_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_overrun: got overrun, none expected");
                    end else begin
                        e = exp_q.pop_front();
                        check1("overrun_expected", 32'(e.is_ovr), 32'd1);
                    end
                end
                pv = valid_o;
                pa = valid_o && ready_i;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check1("rst_valid", 32'(valid_o), 32'd0);
        check1("rst_data", 32'(data_o), 32'd0);
        check1("rst_perr", 32'(parity_err_o), 32'd0);
        check1("rst_ferr", 32'(frame_err_o), 32'd0);
        check1("rst_ovr", 32'(overrun_o), 32'd0);
        check1("rst_busy", 32'(busy_o), 32'd0);
        reset_ni = 1'b1;
        ready_i  = 1'b1;
        repeat (4) tick();

        // 8N1 basic frame, single-cycle valid
        push_word(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        check1("a5_valid_one_cycle", 32'(valid_o), 32'd0);
        repeat (4) tick();

        // Parity: 0x41 has two ones, even expects 0, odd expects 1
        parity_mode_i = 2'b01;
        push_word(8'h41, 1'b1, 1'b0);
        send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        push_word(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        parity_mode_i = 2'b10;
        push_word(8'h41, 1'b1, 1'b0);
        send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        parity_mode_i = 2'b11;
        push_word(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        // Mode latched at start: change to none mid-frame must be ignored
        parity_mode_i = 2'b01;
        push_word(8'h03, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b1, 2'b00);
        repeat (4) tick();

        // Framing error then line held low for 40 bit times
        parity_mode_i = 2'b00;
        push_word(8'hF0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 2'b00);
        rx_i = 1'b0;
        repeat (40 * CPB) tick();
        check1("break_wait_high_busy", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        repeat (6) tick();
        check1("break_release_idle", 32'(busy_o), 32'd0);

        // Overrun with a stalled consumer
        ready_i = 1'b0;
        push_word(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        push_ovr();
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        check1("ovr_keeps_old", 32'(data_o), 32'h11);
        check1("ovr_valid_held", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        check1("drain_valid", 32'(valid_o), 32'd0);

        // Accept in the delivery cycle: new word loads, no overrun
        push_word(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);
        push_word(8'h22, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 2'b00);
        check1("same_cycle_data", 32'(data_o), 32'h22);
        check1("same_cycle_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        repeat (2) tick();

        // Short low pulse: false start rejected
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        repeat (2) tick();
        check1("glitch_busy_rises", 32'(busy_o), 32'd1);
        repeat (24) tick();
        check1("glitch_busy_falls", 32'(busy_o), 32'd0);
        check1("glitch_no_valid", 32'(valid_o), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inversion exactly at the bit-0 sample point
        push_word(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 25, 1'b0, 2'b00);
        repeat (4) tick();
`endif

        // Reset in the middle of the data bits
        rx_i = 1'b0;
        repeat (CPB) tick();
        rx_i = 1'b1;
        repeat (3 * CPB) tick();
        check1("mid_frame_busy", 32'(busy_o), 32'd1);
        reset_ni = 1'b0;
        repeat (3) tick();
        check1("midrst_data", 32'(data_o), 32'd0);
        check1("midrst_valid", 32'(valid_o), 32'd0);
        check1("midrst_busy", 32'(busy_o), 32'd0);
        check1("midrst_flags", 32'({parity_err_o, frame_err_o, overrun_o}), 32'd0);
        reset_ni = 1'b1;
        repeat (3) tick();
        push_word(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 2'b00);

        repeat (20) tick();
        check1("all_expected_seen", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
